dmem_ctrl: RTL and testbench

Parametrised, handshaked data memory for the sequential Y86-64 core. Decodes `icode` to select the access address and write data, and performs the read or write after a configurable number of wait cycles. Reports out-of-range and, optionally, misaligned accesses on a sticky error flag. Sits in the memory stage; the core holds its PC/register update until `done`.

---
 rtl/dmem_ctrl.sv | 152 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Handshaked data memory for the sequential Y86-64 core (memory stage).
// Latency: memory op completes LAT+1 cycles after accept, no-op after 1; `done` pulses one cycle.
// Backpressure: one request in flight; `req` is ignored until the FSM is back in IDLE.
// Ports: clk, rst_n (async active-low); req/icode/valE/valA/valP request side;
//        busy, done, valM (read data), dmem_error (sticky) result side.
// Optional: define DMEM_ALIGN_CHECK_EN to flag misaligned byte addresses as errors.
module dmem_ctrl #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [3:0]       icode,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valP,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] valM,
  output logic             dmem_error
);

  localparam int BYTES = WIDTH / 8;
  localparam int OFFS  = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(DEPTH) * WIDTH'(BYTES);
`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] OFF_MASK = WIDTH'(BYTES - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR} op_t;

  state_t           state_q;
  op_t              op_q;
  logic [3:0]       cnt_q;
  logic [AW-1:0]    idx_q;
  logic [WIDTH-1:0] wdat_q;
  logic             bad_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] valm_q;
  logic             err_q;

  logic [WIDTH-1:0] mem_q [DEPTH];

  op_t              dec_op;
  logic [WIDTH-1:0] dec_addr;
  logic [WIDTH-1:0] dec_wdat;
  logic             dec_bad;
  logic             mem_we_d;

  // icode decode: which operand is the address and which is the write data.
  always_comb begin
    dec_op   = OP_NONE;
    dec_addr = valE;
    dec_wdat = valA;
    case (icode)
      4'h4, 4'hA: dec_op = OP_WR;
      4'h8: begin
        dec_op   = OP_WR;
        dec_wdat = valP;
      end
      4'h5: dec_op = OP_RD;
      4'h9, 4'hB: begin
        dec_op   = OP_RD;
        dec_addr = valA;
      end
      default: dec_op = OP_NONE;
    endcase
  end

  always_comb begin
    dec_bad = (dec_addr >= LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
    dec_bad = dec_bad | ((dec_addr & OFF_MASK) != '0);
`endif
  end

  // The access edge is the last WAIT cycle; a bad address never writes.
  assign mem_we_d = (state_q == S_WAIT) && (cnt_q == 4'd0) && (op_q == OP_WR) && !bad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdat_q  <= '0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valm_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            op_q   <= dec_op;
            idx_q  <= AW'(dec_addr >> OFFS);
            wdat_q <= dec_wdat;
            bad_q  <= dec_bad && (dec_op != OP_NONE);
            busy_q <= 1'b1;
            if (dec_op == OP_NONE) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(LAT - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            if (bad_q) begin
              err_q <= 1'b1;
              if (op_q == OP_RD) valm_q <= '0;
            end else if (op_q == OP_RD) begin
              valm_q <= mem_q[idx_q];
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[idx_q] <= wdat_q;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign valM       = valm_q;
  assign dmem_error = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: instance 0 with LAT=1, instance 1 with LAT=4.
// A transaction-timeline model predicts done/busy/valM/dmem_error each cycle.
// Directed scenarios add hand-computed literal expectations.
module tb_dmem_ctrl;

  localparam int LAT0 = 1;
  localparam int LAT1 = 4;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_v [2];
  logic [3:0]  ic_v [2];
  logic [63:0] e_v [2];
  logic [63:0] a_v [2];
  logic [63:0] p_v [2];
  logic        busy_v [2];
  logic        done_v [2];
  logic [63:0] valm_v [2];
  logic        err_v [2];

  dmem_ctrl #(.WIDTH(64), .DEPTH(1024), .LAT(LAT0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .icode(ic_v[0]),
    .valE(e_v[0]), .valA(a_v[0]), .valP(p_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .valM(valm_v[0]), .dmem_error(err_v[0])
  );
  dmem_ctrl #(.WIDTH(64), .DEPTH(1024), .LAT(LAT1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .icode(ic_v[1]),
    .valE(e_v[1]), .valA(a_v[1]), .valP(p_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .valM(valm_v[1]), .dmem_error(err_v[1])
  );

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_act [2] = '{1'b0, 1'b0};
  int          m_de [2] = '{0, 0};
  int          m_kind [2] = '{0, 0};
  logic [63:0] m_ad [2];
  logic [63:0] m_wd [2];
  bit          e_done [2] = '{1'b0, 1'b0};
  bit          e_busy [2] = '{1'b0, 1'b0};
  bit          e_err [2] = '{1'b0, 1'b0};
  bit          e_vk [2] = '{1'b1, 1'b1};
  logic [63:0] e_valm [2] = '{64'd0, 64'd0};
  logic [63:0] mmem [int];
  int          ecnt = 0;

  function automatic int latof(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  // kind: 0 no-op, 1 read, 2 write
  function automatic void mdec(input logic [3:0] ic, input logic [63:0] e, a, p,
                               output int kind, output logic [63:0] ad, output logic [63:0] wd);
    kind = 0; ad = e; wd = a;
    case (ic)
      4'h4, 4'hA: kind = 2;
      4'h8: begin kind = 2; wd = p; end
      4'h5: kind = 1;
      4'h9, 4'hB: begin kind = 1; ad = a; end
      default: kind = 0;
    endcase
  endfunction

  task automatic m_access(input int i);
    int key;
    bit bad;
    bad = (m_ad[i] >= 64'd8192) || (ALN && (m_ad[i] % 8 != 0));
    key = i * 4096 + int'(m_ad[i] / 8);
    if (m_kind[i] == 0) return;
    if (bad) begin
      e_err[i] = 1'b1;
      if (m_kind[i] == 1) begin e_valm[i] = 64'd0; e_vk[i] = 1'b1; end
    end else if (m_kind[i] == 2) begin
      mmem[key] = m_wd[i];
    end else if (mmem.exists(key)) begin
      e_valm[i] = mmem[key]; e_vk[i] = 1'b1;
    end else begin
      e_vk[i] = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0; e_done[i] = 1'b0; e_busy[i] = 1'b0;
        e_err[i] = 1'b0; e_valm[i] = 64'd0; e_vk[i] = 1'b1;
      end
    end else begin
      ecnt++;
      for (int i = 0; i < 2; i++) begin
        e_done[i] = 1'b0;
        if (m_act[i]) begin
          if (ecnt == m_de[i]) begin
            m_access(i);
            e_done[i] = 1'b1;
          end else if (ecnt == m_de[i] + 1) begin
            m_act[i] = 1'b0;
          end
        end else if (req_v[i]) begin
          mdec(ic_v[i], e_v[i], a_v[i], p_v[i], m_kind[i], m_ad[i], m_wd[i]);
          m_act[i] = 1'b1;
          m_de[i]  = ecnt + ((m_kind[i] == 0) ? 0 : latof(i));
          if (m_kind[i] == 0) e_done[i] = 1'b1;
        end
        e_busy[i] = m_act[i];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d_done", i), 64'(done_v[i]), 64'(e_done[i]));
        chk($sformatf("u%0d_busy", i), 64'(busy_v[i]), 64'(e_busy[i]));
        chk($sformatf("u%0d_err", i), 64'(err_v[i]), 64'(e_err[i]));
        if (e_vk[i]) chk($sformatf("u%0d_valM", i), valm_v[i], e_valm[i]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_op(input int s, input logic [3:0] ic, input logic [63:0] e, a, p,
                       output int lat_n, output logic [63:0] vm, output logic er);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_v[s] && n < 50);
    if (n >= 50) chk("idle_wait", 64'(busy_v[s]), 64'd0);
    ic_v[s] = ic; e_v[s] = e; a_v[s] = a; p_v[s] = p; req_v[s] = 1'b1;
    @(negedge clk);
    req_v[s] = 1'b0;
    ic_v[s] = 4'($urandom); e_v[s] = {$urandom, $urandom};
    a_v[s] = {$urandom, $urandom}; p_v[s] = {$urandom, $urandom};
    lat_n = 1;
    while (!done_v[s] && lat_n < 40) begin
      @(negedge clk);
      lat_n++;
    end
    vm = valm_v[s];
    er = err_v[s];
  endtask

  function automatic logic [63:0] raddr();
    int r = $urandom_range(0, 15);
    logic [63:0] b = 64'($urandom_range(0, 15)) * 64'd8;
    if (r == 0) b = 64'h2000 + 64'($urandom_range(0, 4095));
    else if (r == 1) b = b + 64'($urandom_range(1, 7));
    return b;
  endfunction

  logic [3:0] ictab [8] = '{4'h0, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h3};

  initial begin
    int n;
    logic [63:0] vm;
    logic er;
    logic [11:0] dv, bv;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b0; ic_v[i] = 4'h0; e_v[i] = '0; a_v[i] = '0; p_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy_v[0]), 64'd0);
    chk("rst_valM", valm_v[0], 64'd0);

    // write/read
    do_op(0, 4'h4, 64'h40, 64'hDEADBEEF, 64'h0, n, vm, er);
    chk("wr_lat", 64'(n), 64'd2);
    do_op(0, 4'h5, 64'h40, 64'h0, 64'h0, n, vm, er);
    chk("rd_lat", 64'(n), 64'd2);
    chk("rd_valM", vm, 64'hDEADBEEF);
    chk("rd_err", 64'(er), 64'd0);
    // call/ret
    do_op(0, 4'h8, 64'h1F8, 64'h0, 64'h123, n, vm, er);
    do_op(0, 4'h9, 64'h0, 64'h1F8, 64'h0, n, vm, er);
    chk("ret_valM", vm, 64'h123);
    // out of range: 0x2000 would alias word 0 if not suppressed
    do_op(0, 4'h4, 64'h0, 64'h1111, 64'h0, n, vm, er);
    do_op(0, 4'hA, 64'h2000, 64'h7777, 64'h0, n, vm, er);
    chk("oor_err", 64'(er), 64'd1);
    do_op(0, 4'h5, 64'h0, 64'h0, 64'h0, n, vm, er);
    chk("oor_nowrite", vm, 64'h1111);
    do_op(0, 4'hB, 64'h0, 64'h40, 64'h0, n, vm, er);
    chk("pop_valM", vm, 64'hDEADBEEF);
    chk("err_sticky", 64'(er), 64'd1);
    // no-op: one-cycle latency, valM held
    do_op(0, 4'h0, 64'h40, 64'h0, 64'h0, n, vm, er);
    chk("nop_lat", 64'(n), 64'd1);
    chk("nop_valM", vm, 64'hDEADBEEF);
    // reset clears the sticky error
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("err_cleared", 64'(err_v[0]), 64'd0);
    // alignment
    do_op(0, 4'h5, 64'h43, 64'h0, 64'h0, n, vm, er);
    chk("align_valM", vm, ALN ? 64'h0 : 64'hDEADBEEF);
    chk("align_err", 64'(er), ALN ? 64'd1 : 64'd0);

    // LAT=4 with req held high: accepts at k and k+6
    n = 0;
    do begin @(negedge clk); n++; end while (busy_v[1] && n < 50);
    ic_v[1] = 4'h5; e_v[1] = 64'h40; req_v[1] = 1'b1;
    dv = '0; bv = '0;
    for (int j = 1; j < 12; j++) begin
      @(negedge clk);
      dv[j] = done_v[1];
      bv[j] = busy_v[1];
    end
    req_v[1] = 1'b0;
    chk("lat4_done", 64'(dv), 64'h820);
    chk("lat4_busy", 64'(bv), 64'hFBE);

    // reset mid-operation aborts a pending write
    do_op(1, 4'h4, 64'h80, 64'h0, 64'h0, n, vm, er);
    chk("lat4_wr_lat", 64'(n), 64'd5);
    @(negedge clk);
    ic_v[1] = 4'h4; e_v[1] = 64'h80; a_v[1] = 64'h55; req_v[1] = 1'b1;
    @(negedge clk);
    req_v[1] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", 64'(busy_v[1]), 64'd0);
    chk("mid_done", 64'(done_v[1]), 64'd0);
    chk("mid_valM", valm_v[1], 64'd0);
    chk("mid_err", 64'(err_v[1]), 64'd0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    do_op(1, 4'h5, 64'h80, 64'h0, 64'h0, n, vm, er);
    chk("mid_noncommit", vm, 64'd0);

    // randomized traffic on both instances, one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        req_v[i] = ($urandom_range(0, 9) < 7);
        ic_v[i]  = ictab[$urandom_range(0, 7)];
        e_v[i]   = raddr();
        a_v[i]   = ($urandom_range(0, 1) == 1) ? raddr() : {$urandom, $urandom};
        p_v[i]   = {$urandom, $urandom};
      end
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    for (int i = 0; i < 2; i++) req_v[i] = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
